fifo_push_pop_buf: RTL

Synchronous single-clock FIFO that produces the fifofull status checked by the downstream push/pop SVA monitor. It also produces fifoempty, the occupancy count, and error pulses for illegal push and pop attempts. It sits between a producer (push/data_in) and a consumer (pop/data_out). Overflow and underflow attempts are dropped without corrupting state, and are counted for end-of-test reporting.

---
 rtl/fifo_push_pop_buf.sv | 112 +++++++++++
 1 files changed

// File: rtl/fifo_push_pop_buf.sv
// fifo_push_pop_buf: single-clock FIFO with full/empty/count status,
// registered push/pop error pulses and a saturating error counter.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    async active-low reset
//   push       write request
//   pop        read request
//   data_in    write data
//   data_out   head word (fall-through), 0 when empty
//   fifofull   count == DEPTH
//   fifoempty  count == 0
//   fifocount  occupancy 0..DEPTH
//   push_err   pulse: push refused (full, no pop)
//   pop_err    pulse: pop refused (empty)
//   err_count  saturating error event count
module fifo_push_pop_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             fifofull,
  output logic             fifoempty,
  output logic [AW:0]      fifocount,
  output logic             push_err,
  output logic             pop_err,
  output logic [15:0]      err_count
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;

  logic push_ok;
  logic pop_ok;
  logic push_rej;
  logic pop_rej;

  logic [1:0]  err_inc;
  logic [16:0] err_sum;
  logic [15:0] err_next;

  assign fifocount = count_q;
  assign fifofull  = (count_q == (AW+1)'(DEPTH));
  assign fifoempty = (count_q == '0);

  // A pop on the same edge frees a slot, so a push
  // into a full FIFO is still accepted.
  assign push_ok  = push && (!fifofull || pop);
  assign pop_ok   = pop && !fifoempty;
  assign push_rej = push && !pop && fifofull;
  assign pop_rej  = pop && fifoempty;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Full and empty are exclusive, so at most one
  // error per edge; sum kept general anyway.
  assign err_inc  = {1'b0, push_rej} + {1'b0, pop_rej};
  assign err_sum  = {1'b0, err_count} + 17'(err_inc);
  assign err_next = err_sum[16] ? 16'hFFFF
                                : err_sum[15:0];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // DEPTH is a power of two, so pointers wrap
  // naturally at AW bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      push_err  <= 1'b0;
      pop_err   <= 1'b0;
      err_count <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q   <= count_d;
      push_err  <= push_rej;
      pop_err   <= pop_rej;
      err_count <= err_next;
    end
  end

  assign data_out = fifoempty ? '0 : mem[rd_ptr];

endmodule
